dpi_stream_sequencer: RTL and testbench

Front-end packet sequencer for the DPI matcher bank. Accepts a byte-wide tagged packet stream with valid/ready handshake, looks up per-stream regex enables and stream-seen status, and drives the common matcher-bank interface: load_state, new_stream_id, stream_id, enable, char_in/char_in_vld and eop. Inserts the pipeline gaps the registered matcher wrappers need so that state restore completes before the first character and final accept/state settle before eop.

---
 rtl/dpi_stream_sequencer.sv | 154 +++++++++++++++
 tb/tb_dpi_stream_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer.sv
// Packet front end for the DPI matcher bank: per-stream enable/seen lookup and
// load_state / char_in / eop sequencing with restore and settle gaps.
module dpi_stream_sequencer #(
    parameter int unsigned NUM_REGEX = 8,
    parameter int unsigned LOAD_GAP  = 2,
    parameter int unsigned EOP_GAP   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           pkt_data,
    input  logic                 pkt_vld,
    input  logic                 pkt_sop,
    input  logic                 pkt_eop,
    input  logic [5:0]           pkt_stream_id,
    output logic                 pkt_rdy,
    input  logic                 cfg_wr,
    input  logic                 cfg_clr,
    input  logic [5:0]           cfg_stream_id,
    input  logic [NUM_REGEX-1:0] cfg_enable,
    output logic                 load_state,
    output logic                 new_stream_id,
    output logic [5:0]           stream_id,
    output logic [NUM_REGEX-1:0] enable,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic [15:0]          pkt_count,
    output logic [15:0]          err_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP
    } state_t;

    localparam logic [2:0] LOAD_LAST  = 3'(LOAD_GAP - 2);
    localparam logic [2:0] DRAIN_LAST = 3'(EOP_GAP - 1);

    state_t               state;
    logic [NUM_REGEX-1:0] en_tbl [64];
    logic [63:0]          seen;
    logic                 first_byte;
    logic [2:0]           gap_cnt;
    logic [2:0]           drain_cnt;
    logic [2:0]           idle_cnt;

    // pkt_rdy opens in the last restore-gap cycle because the accepted byte
    // reaches char_in one cycle later; STREAM is entered at that point.
    always_comb begin
        pkt_rdy = 1'b0;
        case (state)
            ST_IDLE:   pkt_rdy = pkt_vld & ~pkt_sop;
            ST_STREAM: pkt_rdy = ~(pkt_sop & ~first_byte);
            default:   pkt_rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 64; i++) en_tbl[i] <= '1;
            seen <= '0;
        end else begin
            if (cfg_wr) en_tbl[cfg_stream_id] <= cfg_enable;
            if (state == ST_LOAD) seen[stream_id] <= 1'b1;
            // Retirement of the same stream in the same cycle takes priority.
            if (cfg_clr) seen[cfg_stream_id] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            stream_id     <= '0;
            enable        <= '0;
            char_in       <= '0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            pkt_count     <= '0;
            err_count     <= '0;
            first_byte    <= 1'b0;
            gap_cnt       <= '0;
            drain_cnt     <= '0;
            idle_cnt      <= '0;
        end else begin
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pkt_vld && pkt_sop) begin
                        stream_id     <= pkt_stream_id;
                        enable        <= en_tbl[pkt_stream_id];
                        new_stream_id <= ~seen[pkt_stream_id];
                        load_state    <= 1'b1;
                        state         <= ST_LOAD;
                    end else if (pkt_vld && err_count != '1) begin
                        err_count <= err_count + 16'd1;
                    end
                end
                ST_LOAD: begin
                    gap_cnt    <= 3'd1;
                    first_byte <= 1'b1;
                    idle_cnt   <= '0;
                    state      <= (LOAD_GAP <= 2) ? ST_STREAM : ST_WAIT;
                end
                ST_WAIT: begin
                    if (gap_cnt == LOAD_LAST) state <= ST_STREAM;
                    else gap_cnt <= gap_cnt + 3'd1;
                end
                ST_STREAM: begin
                    if (pkt_vld && pkt_sop && !first_byte) begin
                        // Truncated packet: drain counts from the last char already sent.
                        if (err_count != '1) err_count <= err_count + 16'd1;
                        drain_cnt <= (idle_cnt >= DRAIN_LAST - 3'd1) ? DRAIN_LAST
                                                                      : idle_cnt + 3'd1;
                        state     <= ST_DRAIN;
                    end else if (pkt_vld) begin
                        char_in     <= pkt_data;
                        char_in_vld <= 1'b1;
                        first_byte  <= 1'b0;
                        idle_cnt    <= '0;
                        if (pkt_eop) begin
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end
                    end else if (idle_cnt != 3'd7) begin
                        idle_cnt <= idle_cnt + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt >= DRAIN_LAST) begin
                        eop   <= 1'b1;
                        state <= ST_EOP;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                ST_EOP: begin
                    pkt_count <= pkt_count + 16'd1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: cycle-exact handshake, gap and table checks.
module tb_dpi_stream_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pkt_data;
    logic       pkt_vld, pkt_sop, pkt_eop, pkt_rdy;
    logic [5:0] pkt_stream_id;
    logic       cfg_wr, cfg_clr;
    logic [5:0] cfg_stream_id;
    logic [7:0] cfg_enable;
    logic       load_state, new_stream_id, char_in_vld, eop;
    logic [5:0] stream_id;
    logic [7:0] enable, char_in;
    logic [15:0] pkt_count, err_count;

    dpi_stream_sequencer #(.NUM_REGEX(8), .LOAD_GAP(2), .EOP_GAP(3)) dut (
        .clk(clk), .rst(rst),
        .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_stream_id(pkt_stream_id), .pkt_rdy(pkt_rdy),
        .cfg_wr(cfg_wr), .cfg_clr(cfg_clr), .cfg_stream_id(cfg_stream_id), .cfg_enable(cfg_enable),
        .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
        .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int         load_q[$], eop_q[$], chr_q[$];
    logic       new_q[$];
    logic [5:0] id_q[$];
    logic [7:0] en_q[$], eop_en_q[$], dat_q[$];
    logic       in_pkt = 1'b0, hold_bad = 1'b0;
    logic [7:0] cur_en;
    logic [5:0] cur_id;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (load_state) begin
                load_q.push_back(cyc); new_q.push_back(new_stream_id);
                id_q.push_back(stream_id); en_q.push_back(enable);
                in_pkt = 1'b1; cur_en = enable; cur_id = stream_id;
            end else if (in_pkt && (enable !== cur_en || stream_id !== cur_id)) begin
                hold_bad = 1'b1;
            end
            if (char_in_vld) begin chr_q.push_back(cyc); dat_q.push_back(char_in); end
            if (eop) begin eop_q.push_back(cyc); eop_en_q.push_back(enable); in_pkt = 1'b0; end
        end
    end

    task automatic clear_log;
        load_q.delete(); eop_q.delete(); chr_q.delete(); new_q.delete();
        id_q.delete(); en_q.delete(); eop_en_q.delete(); dat_q.delete();
        in_pkt = 1'b0; hold_bad = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e,
                             input logic [5:0] id, output int acc);
        logic got;
        got = 1'b0; acc = -1;
        pkt_data = d; pkt_sop = s; pkt_eop = e; pkt_stream_id = id; pkt_vld = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (pkt_rdy) begin got = 1'b1; acc = cyc; end
            @(posedge clk); #1;
        end
        pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL handshake: byte %h not accepted within 40 cycles (rdy 0, need 1)", d);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; pkt_vld = 0; pkt_sop = 0; pkt_eop = 0; pkt_data = 0; pkt_stream_id = 0;
        cfg_wr = 0; cfg_clr = 0; cfg_stream_id = 0; cfg_enable = 0;
        idle(3);
        n_checks++;
        if ({load_state, new_stream_id, char_in_vld, eop, pkt_rdy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b need 00000",
                               {load_state, new_stream_id, char_in_vld, eop, pkt_rdy});
        end
        n_checks++;
        if ({stream_id, enable, char_in, pkt_count, err_count} !== '0) begin
            n_fail++; $display("FAIL reset_data: id %h en %h ch %h pc %h ec %h need all 0",
                               stream_id, enable, char_in, pkt_count, err_count);
        end
        rst = 1'b0;
        idle(2);
        n_checks++;
        if (load_state !== 1'b0 || pkt_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_idle: load %b pc %0d need 0 0", load_state, pkt_count);
        end
    endtask

    task automatic test_basic;
        int t0, a;
        int         exp_c[3];
        logic [7:0] exp_d[3];
        clear_log(); t0 = cyc;
        send_byte(8'h41, 1, 0, 6'd5, a);
        send_byte(8'h42, 0, 0, 6'd5, a);
        send_byte(8'h43, 0, 1, 6'd5, a);
        idle(8);
        exp_c = '{t0 + 3, t0 + 4, t0 + 5};
        exp_d = '{8'h41, 8'h42, 8'h43};
        n_checks++;
        if (load_q.size() != 1 || load_q[0] != t0 + 1) begin
            n_fail++; $display("FAIL basic_load_cycle: got %0d loads first at %0d need 1 at %0d",
                               load_q.size(), load_q[0], t0 + 1);
        end
        n_checks++;
        if (new_q[0] !== 1'b1 || id_q[0] !== 6'd5 || en_q[0] !== 8'hFF) begin
            n_fail++; $display("FAIL basic_load_info: new %b id %0d en %h need 1 5 ff",
                               new_q[0], id_q[0], en_q[0]);
        end
        n_checks++;
        if (chr_q.size() != 3) begin
            n_fail++; $display("FAIL basic_char_count: got %0d need 3", chr_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (chr_q[i] != exp_c[i] || dat_q[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL basic_char%0d: got %h at %0d need %h at %0d",
                                   i, dat_q[i], chr_q[i], exp_d[i], exp_c[i]);
            end
        end
        n_checks++;
        if (eop_q.size() != 1 || eop_q[0] != t0 + 8) begin
            n_fail++; $display("FAIL basic_eop: got %0d eops first at %0d need 1 at %0d",
                               eop_q.size(), eop_q[0], t0 + 8);
        end
        n_checks++;
        if (pkt_count !== 16'd1 || hold_bad !== 1'b0) begin
            n_fail++; $display("FAIL basic_count: pc %0d hold_bad %b need 1 0", pkt_count, hold_bad);
        end
    endtask

    task automatic test_seen;
        int t0, a;
        clear_log();
        send_byte(8'h55, 1, 1, 6'd5, a);
        idle(8);
        n_checks++;
        if (load_q.size() != 1 || new_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL seen_repeat: loads %0d new %b need 1 0", load_q.size(), new_q[0]);
        end
        cfg_clr = 1'b1; cfg_stream_id = 6'd5; idle(1); cfg_clr = 1'b0;
        clear_log(); t0 = cyc;
        send_byte(8'h56, 1, 1, 6'd5, a);
        idle(8);
        n_checks++;
        if (new_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL seen_cleared: new %b need 1", new_q[0]);
        end
        n_checks++;
        if (chr_q.size() != 1 || chr_q[0] != t0 + 3 || eop_q[0] != t0 + 6) begin
            n_fail++; $display("FAIL single_byte: chars %0d at %0d eop %0d need 1 at %0d eop %0d",
                               chr_q.size(), chr_q[0], eop_q[0], t0 + 3, t0 + 6);
        end
        n_checks++;
        if (pkt_count !== 16'd3) begin
            n_fail++; $display("FAIL seen_count: pc %0d need 3", pkt_count);
        end
    endtask

    task automatic test_cfg;
        int a;
        cfg_wr = 1'b1; cfg_stream_id = 6'd9; cfg_enable = 8'h05; idle(1); cfg_wr = 1'b0;
        clear_log();
        send_byte(8'h90, 1, 0, 6'd9, a);
        cfg_wr = 1'b1; cfg_enable = 8'h00;
        send_byte(8'h91, 0, 0, 6'd9, a);
        cfg_wr = 1'b0;
        send_byte(8'h92, 0, 1, 6'd9, a);
        idle(8);
        n_checks++;
        if (en_q[0] !== 8'h05 || eop_en_q[0] !== 8'h05 || hold_bad !== 1'b0) begin
            n_fail++; $display("FAIL cfg_inflight: load en %h eop en %h hold_bad %b need 05 05 0",
                               en_q[0], eop_en_q[0], hold_bad);
        end
        clear_log();
        send_byte(8'h93, 1, 1, 6'd9, a);
        idle(8);
        n_checks++;
        if (en_q[0] !== 8'h00 || new_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL cfg_next: en %h new %b need 00 0", en_q[0], new_q[0]);
        end
    endtask

    task automatic test_gaps;
        int t0, a;
        int exp_c[3];
        clear_log(); t0 = cyc;
        send_byte(8'hA0, 1, 0, 6'd3, a);
        idle(2);
        send_byte(8'hA1, 0, 0, 6'd3, a);
        idle(1);
        send_byte(8'hA2, 0, 1, 6'd3, a);
        idle(8);
        exp_c = '{t0 + 3, t0 + 6, t0 + 8};
        n_checks++;
        if (chr_q.size() != 3) begin
            n_fail++; $display("FAIL gaps_count: got %0d need 3", chr_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (chr_q[i] != exp_c[i]) begin
                n_fail++; $display("FAIL gaps_char%0d: at %0d need %0d", i, chr_q[i], exp_c[i]);
            end
        end
        n_checks++;
        if (eop_q[0] != t0 + 11 || new_q[0] !== 1'b1) begin
            n_fail++; $display("FAIL gaps_eop: eop %0d new %b need %0d 1", eop_q[0], new_q[0], t0 + 11);
        end
    endtask

    task automatic test_orphan;
        int a;
        clear_log();
        send_byte(8'hEE, 0, 0, 6'd0, a);
        send_byte(8'hEF, 0, 0, 6'd0, a);
        idle(3);
        n_checks++;
        if (err_count !== 16'd2 || load_q.size() != 0 || chr_q.size() != 0) begin
            n_fail++; $display("FAIL orphan: err %0d loads %0d chars %0d need 2 0 0",
                               err_count, load_q.size(), chr_q.size());
        end
    endtask

    task automatic test_truncate;
        int t0, a;
        int exp_c[3];
        clear_log(); t0 = cyc;
        send_byte(8'hB0, 1, 0, 6'd7, a);
        send_byte(8'hB1, 0, 0, 6'd7, a);
        send_byte(8'hC0, 1, 1, 6'd8, a);
        idle(8);
        exp_c = '{t0 + 3, t0 + 4, t0 + 11};
        n_checks++;
        if (err_count !== 16'd3) begin
            n_fail++; $display("FAIL trunc_err: got %0d need 3", err_count);
        end
        n_checks++;
        if (eop_q.size() != 2 || eop_q[0] != t0 + 7 || eop_q[1] != t0 + 14) begin
            n_fail++; $display("FAIL trunc_eop: %0d eops at %0d,%0d need 2 at %0d,%0d",
                               eop_q.size(), eop_q[0], eop_q[1], t0 + 7, t0 + 14);
        end
        n_checks++;
        if (load_q.size() != 2 || load_q[1] != t0 + 9 || id_q[1] !== 6'd8 || new_q[1] !== 1'b1) begin
            n_fail++; $display("FAIL trunc_reload: loads %0d at %0d id %0d new %b need 2 at %0d id 8 new 1",
                               load_q.size(), load_q[1], id_q[1], new_q[1], t0 + 9);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (chr_q[i] != exp_c[i]) begin
                n_fail++; $display("FAIL trunc_char%0d: at %0d need %0d", i, chr_q[i], exp_c[i]);
            end
        end
        n_checks++;
        if (pkt_count !== 16'd8) begin
            n_fail++; $display("FAIL trunc_count: pc %0d need 8", pkt_count);
        end
    endtask

    task automatic test_reset_mid;
        int a;
        clear_log();
        send_byte(8'hD0, 1, 0, 6'd5, a);
        rst = 1'b1; #1;
        n_checks++;
        if ({load_state, char_in_vld, eop, pkt_rdy} !== 4'b0 ||
            {stream_id, enable, char_in, pkt_count, err_count} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: vld %b id %0d en %h pc %0d ec %0d need all 0",
                               char_in_vld, stream_id, enable, pkt_count, err_count);
        end
        idle(2); rst = 1'b0; idle(10);
        n_checks++;
        if (eop_q.size() != 0) begin
            n_fail++; $display("FAIL rst_mid_no_eop: got %0d eops need 0", eop_q.size());
        end
        clear_log();
        send_byte(8'hD1, 1, 1, 6'd5, a);
        idle(8);
        n_checks++;
        if (new_q[0] !== 1'b1 || en_q[0] !== 8'hFF || pkt_count !== 16'd1) begin
            n_fail++; $display("FAIL rst_mid_next: new %b en %h pc %0d need 1 ff 1",
                               new_q[0], en_q[0], pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seen();
        test_cfg();
        test_gaps();
        test_orphan();
        test_truncate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (done 0, need 1)");
        $fatal(1, "watchdog");
    end

endmodule
